// File: rtl/config_frame_loader.sv
// Configuration frame loader: parses a 32-bit word stream (SYNC, WRITE header,
// data, DESYNC). It drives frame data, a one-hot frame strobe and a column
// address into latch-based configuration memory. Setup and hold margins keep
// the transparent latches safe.
// Optional feature macro: CFG_LOADER_CHECKSUM_EN. When it is defined, each
// WRITE is followed by an XOR checksum word.
module config_frame_loader #(
  parameter int unsigned NUM_COLUMNS    = 16,
  parameter int unsigned FRAMES_PER_COL = 20,
  parameter int unsigned SETUP_CYC      = 1,
  parameter int unsigned STROBE_CYC     = 2,
  localparam int unsigned COL_W         = $clog2(NUM_COLUMNS),
  localparam int unsigned PTR_W         = $clog2(FRAMES_PER_COL)
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic [31:0]               s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [31:0]               frame_data,
  output logic [FRAMES_PER_COL-1:0] frame_strobe,
  output logic [COL_W-1:0]          col_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;

`ifdef CFG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StSynced, StWaitData, StSetup, StStrobe, StHold, StCheck
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StSynced, StWaitData, StSetup, StStrobe, StHold
  } state_e;
`endif

  state_e                    state_q, state_d;
  logic [31:0]               data_q, data_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [COL_W-1:0]          hdr_col_q, hdr_col_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [7:0]                rem_q, rem_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;
  logic [FRAMES_PER_COL-1:0] strobe_q, strobe_d;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [31:0]               xor_q, xor_d;
`endif

  logic       accept;
  logic       is_sync;
  logic [3:0] opcode;
  logic [7:0] hdr_n;
  logic [8:0] hdr_end;
  logic       hdr_bad;

  assign is_sync = (s_data == SyncWord);
  assign opcode  = s_data[31:28];
  assign hdr_n   = s_data[23:16];
  // End frame of the write is computed one bit wider so f0+N cannot wrap.
  assign hdr_end = {1'b0, hdr_n} + {4'b0, s_data[4:0]};
  assign hdr_bad = (hdr_n == 8'd0) ||
                   ({1'b0, s_data[15:8]} >= 9'(NUM_COLUMNS)) ||
                   (hdr_end > 9'(FRAMES_PER_COL));

  // Word acceptance is only possible in the parsing states.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      StIdle, StSynced, StWaitData: s_ready = 1'b1;
`ifdef CFG_LOADER_CHECKSUM_EN
      StCheck:                      s_ready = 1'b1;
`endif
      default:                      s_ready = 1'b0;
    endcase
  end

  assign accept = s_valid & s_ready;

  // Next-state logic for the parser and the frame write sequencer.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    col_d     = col_q;
    hdr_col_d = hdr_col_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept && is_sync) begin
          state_d = StSynced;
          err_d   = 1'b0;
        end
      end
      StSynced: begin
        if (accept) begin
          // SYNC also carries the 4'hF opcode, so it must be decoded first.
          if (is_sync) begin
            err_d = 1'b0;
          end else if (opcode == 4'hF) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (opcode == 4'h1) begin
            if (hdr_bad) begin
              err_d = 1'b1;
            end else begin
              state_d   = StWaitData;
              ptr_d     = PTR_W'(s_data[4:0]);
              rem_d     = hdr_n;
              hdr_col_d = s_data[8 +: COL_W];
`ifdef CFG_LOADER_CHECKSUM_EN
              xor_d     = '0;
`endif
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWaitData: begin
        if (accept) begin
          data_d  = s_data;
          col_d   = hdr_col_q;
          cnt_d   = 8'd0;
          state_d = StSetup;
`ifdef CFG_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ s_data;
`endif
        end
      end
      StSetup: begin
        if (cnt_q == 8'(SETUP_CYC - 1)) begin
          cnt_d   = 8'd0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 8'(STROBE_CYC - 1)) begin
          cnt_d   = 8'd0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
`ifdef CFG_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StSynced;
`endif
        end else begin
          // Pointer only advances when another frame follows, so it stays in range.
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = StWaitData;
        end
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          if (s_data != xor_q) err_d = 1'b1;
          state_d = StSynced;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Strobe is registered so the latch enables are glitch-free.
    strobe_d = '0;
    if (state_d == StStrobe) begin
      strobe_d = {{(FRAMES_PER_COL-1){1'b0}}, 1'b1} << ptr_q;
    end
  end

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      data_q    <= '0;
      col_q     <= '0;
      hdr_col_q <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      col_q     <= col_d;
      hdr_col_q <= hdr_col_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
`ifdef CFG_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign frame_data   = data_q;
  assign frame_strobe = strobe_q;
  assign col_addr     = col_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;

endmodule
